alu_muldiv: RTL

- Iterative multiply/divide unit implementing the RV32M operations; it is the parametrised, multi-cycle companion to the combinational datapath ALU.
- Sits in the execute stage beside the ALU and is selected when the decoder flags an M-extension instruction.
- Uses a valid/ready handshake on both sides so the pipeline can stall while the unit is busy.
- Accepts one operation at a time: shift-add multiply, restoring divide, and a fast path for division corner cases.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_muldiv.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared types for the M-extension multiply/divide unit.
// Opcode encoding matches RV32M funct3.
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
// Shift-add multiply, restoring divide, fast path for div corner cases.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    muldiv_state_e state;
    muldiv_op_e    op_q;
    logic          sign_a;
    logic          sign_b;
    logic [W-1:0]  opb;
    logic [2*W-1:0] acc;
    logic [CW-1:0] cnt;

    muldiv_op_e   op_in;
    logic         a_signed;
    logic         b_signed;
    logic         sa_in;
    logic         sb_in;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic         div_zero;
    logic         div_ovf;
    logic         fast;
    logic [W-1:0] fast_res;

    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic [W-1:0]   fix_res;

    // Decode the incoming operation: signedness, magnitudes, fast path.
    always_comb begin
        op_in    = muldiv_op_e'(Operation[2:0]);
        a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU,
                                 OP_DIV, OP_REM};
        b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sa_in    = a_signed & SrcA[W-1];
        sb_in    = b_signed & SrcB[W-1];
        a_mag    = sa_in ? -SrcA : SrcA;
        b_mag    = sb_in ? -SrcB : SrcB;
        div_zero = (SrcB == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM})
                   && (SrcA == MOST_NEG) && (SrcB == '1);
        fast     = Operation[2] && (div_zero || div_ovf);
        fast_res = '0;
        unique case (1'b1)
            div_zero && !Operation[1]: fast_res = '1;
            div_zero &&  Operation[1]: fast_res = SrcA;
            !div_zero && !Operation[1]: fast_res = SrcA;
            default:                   fast_res = '0;
        endcase
    end

    // Shared adder: trial subtract for divide, partial-product add for multiply.
    always_comb begin
        if (op_q[2]) begin
            sum = acc[2*W-1:W-1] - {1'b0, opb};
        end else begin
            sum = {1'b0, acc[2*W-1:W]} + {1'b0, opb};
        end
    end

    // Sign correction applied in FIX; unsigned ops carry zero sign flags.
    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quot = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
        rem  = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem : quot;
        end else if (op_q == OP_MUL) begin
            fix_res = prod[W-1:0];
        end else begin
            fix_res = prod[2*W-1:W];
        end
    end

    // Control FSM and iterative datapath with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Result    <= '0;
            op_q      <= OP_MUL;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            opb       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_in;
                        sign_a   <= sa_in;
                        sign_b   <= sb_in;
                        opb      <= b_mag;
                        acc      <= {{W{1'b0}}, a_mag};
                        cnt      <= CNT_INIT;
                        in_ready <= 1'b0;
                        if (fast) begin
                            Result    <= fast_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!sum[W]) begin
                            acc <= {sum[W-1:0], acc[W-2:0], 1'b1};
                        end else begin
                            acc <= {acc[2*W-2:0], 1'b0};
                        end
                    end else begin
                        if (acc[0]) begin
                            acc <= {sum, acc[W-1:1]};
                        end else begin
                            acc <= {1'b0, acc[2*W-1:1]};
                        end
                    end
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result    <= fix_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
